// File: rtl/arith_pkg.sv
// Shared definitions for the arithmetic datapath (multiplier and divider).
package arith_pkg;

    // Control states shared by the sequential arithmetic units.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    // Default operand width, kept common with the divider so both stay matched.
    localparam int DEFAULT_WIDTH = 4;

    // Step counter width: enough to count WIDTH steps, never narrower than 1 bit.
    function automatic int cnt_width(input int w);
        int c;
        c = $clog2(w);
        return (c < 1) ? 1 : c;
    endfunction

    localparam int CNT_WIDTH = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/seq_mul_add_mul_step.sv
// One shift-and-add step: conditionally add the multiplicand into the high
// half of the accumulator, then shift {acc_hi, acc_lo} right by one.
module mul_step
    import arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH:0]   acc_hi,
    input  logic [WIDTH-1:0] acc_lo,
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH:0]   next_hi,
    output logic [WIDTH-1:0] next_lo
);

    logic [WIDTH:0] sum;

    // Conditional add at WIDTH+1 bits keeps the carry, then logical right shift.
    always_comb begin
        sum     = acc_hi + (acc_lo[0] ? {1'b0, a} : '0);
        next_hi = {1'b0, sum[WIDTH:1]};
        next_lo = {sum[0], acc_lo[WIDTH-1:1]};
    end

endmodule

// File: rtl/seq_mul_add.sv
// Sequential unsigned multiply-add, p = a*b + c, one multiplier bit per clock.
// Also rebuilds a dividend from divider results: dividend = q*divisor + r.
//
// Handshake: start is sampled only while idle (busy low); a, b and c are
// captured on that accept edge. busy is high from the accept edge until the
// result is written. done pulses for exactly one cycle together with the new
// p, and p holds until the next completion. start while busy is dropped; start
// during the done cycle is accepted because the unit is already idle again.
module seq_mul_add
    import arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [WIDTH-1:0]   c,
    output logic [2*WIDTH-1:0] p,
    output logic               busy,
    output logic               done
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH:0]   acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] c_reg;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   step_hi;
    logic [WIDTH-1:0] step_lo;

    mul_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc_hi  (acc_hi),
        .acc_lo  (acc_lo),
        .a       (a_reg),
        .next_hi (step_hi),
        .next_lo (step_lo)
    );

    // busy is decoded straight from the state register.
    always_comb begin
        busy = (state != IDLE);
    end

    // Control FSM plus datapath registers; done is cleared on every edge it is not set.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            acc_hi <= '0;
            acc_lo <= '0;
            a_reg  <= '0;
            c_reg  <= '0;
            cnt    <= '0;
            p      <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        acc_hi <= '0;
                        acc_lo <= b;
                        a_reg  <= a;
                        c_reg  <= c;
                        cnt    <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST_STEP) begin
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    // The product fits in 2*WIDTH bits, so the top carry bit is zero here.
                    p     <= {acc_hi[WIDTH-1:0], acc_lo} + {{WIDTH{1'b0}}, c_reg};
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mul_add.sv
// Randomized and directed bench for seq_mul_add with a scoreboard queue.
module tb_seq_mul_add;

  localparam int W = 4;
  localparam int LAT = W + 1;   // edges from accept edge to the edge that raises done

  logic           clk;
  logic           rst;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [W-1:0]   c;
  logic [2*W-1:0] p;
  logic           busy;
  logic           done;

  seq_mul_add #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .c     (c),
    .p     (p),
    .busy  (busy),
    .done  (done)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  logic [2*W-1:0] exp_q[$];
  int             exp_edge_q[$];
  logic [2*W-1:0] last_exp;
  int             edge_n;
  int             free_edge;
  int             busy_until;
  int             n_compared;
  int             n_failed;

  initial begin
    edge_n     = 0;
    free_edge  = 0;
    busy_until = 0;
    last_exp   = '0;
    n_compared = 0;
    n_failed   = 0;
  end

  task automatic check(input string name, input longint actual, input longint required);
    n_compared++;
    if (actual != required) begin
      n_failed++;
      $display("FAIL %s: got %0d, wanted %0d (edge %0d)", name, actual, required, edge_n);
    end
  endtask

  // Reference: plain arithmetic, widened so nothing is lost.
  function automatic logic [2*W-1:0] ref_result(input int ai, input int bi, input int ci);
    int r;
    r = ai * bi + ci;
    return r[2*W-1:0];
  endfunction

  // driver: one clock of stimulus; the model decides acceptance from its own timeline
  task automatic step(input logic r, input logic s, input int ai, input int bi, input int ci);
    rst   = r;
    start = s;
    a     = ai[W-1:0];
    b     = bi[W-1:0];
    c     = ci[W-1:0];
    @(posedge clk);
    edge_n++;
    if (r) begin
      exp_q.delete();
      exp_edge_q.delete();
      busy_until = 0;
      free_edge  = edge_n + 1;
      last_exp   = '0;
    end else if (s && edge_n >= free_edge) begin
      exp_q.push_back(ref_result(ai, bi, ci));
      exp_edge_q.push_back(edge_n + LAT);
      busy_until = edge_n + LAT;
      free_edge  = edge_n + LAT + 1;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
  endtask

  task automatic issue(input int ai, input int bi, input int ci);
    step(1'b0, 1'b1, ai, bi, ci);
    idle(LAT);
  endtask

  // monitor: samples on the falling edge, pops the scoreboard on done
  always @(negedge clk) begin
    if (edge_n > 0) begin
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          last_exp = exp_q.pop_front();
          check("done_latency_edge", edge_n, exp_edge_q.pop_front());
        end
      end else if (exp_edge_q.size() > 0 && edge_n >= exp_edge_q[0]) begin
        check("missed_done_edge", edge_n, exp_edge_q[0]);
        void'(exp_q.pop_front());
        void'(exp_edge_q.pop_front());
      end
      check("p", p, last_exp);
      check("busy", busy, (edge_n < busy_until) ? 1 : 0);
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; c = '0;

    // reset then idle
    step(1'b1, 1'b0, 0, 0, 0);
    step(1'b1, 1'b1, 5, 5, 5);
    check("reset_p", p, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    idle(10);

    // basic, max, zeros
    issue(3, 5, 2);
    check("basic_p", p, 17);
    idle(3);
    check("basic_hold_p", p, 17);
    issue(15, 15, 15);
    check("max_p", p, 240);
    issue(0, 9, 7);
    check("zero_a_p", p, 7);
    issue(9, 0, 7);
    check("zero_b_p", p, 7);

    // start held high with operands changing every cycle; starts while busy are dropped
    for (int i = 0; i < 60; i++) step(1'b0, 1'b1, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
    idle(LAT + 1);

    // reset on the third RUN edge aborts the computation
    step(1'b0, 1'b1, 13, 11, 6);
    idle(2);
    step(1'b1, 1'b0, 0, 0, 0);
    check("abort_p", p, 0);
    check("abort_busy", busy, 0);
    idle(LAT + 2);
    issue(2, 7, 1);
    check("after_abort_p", p, 15);

    // random start traffic with occasional reset
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
    end
    idle(LAT + 1);

    // exhaustive sweep
    for (int ai = 0; ai < 16; ai++)
      for (int bi = 0; bi < 16; bi++)
        for (int ci = 0; ci < 16; ci++)
          issue(ai, bi, ci);

    // rebuild every dividend from divider results
    for (int n = 0; n < 16; n++) begin
      for (int d = 1; d < 16; d++) begin
        issue(d, n / d, n % d);
        check("rebuild_dividend", p, n);
      end
    end

    idle(LAT + 2);
    check("scoreboard_left", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule
